// File: rtl/iq_demod_pkg.sv
// Shared helpers for the IQ lock-in demodulator: accumulator sizing,
// output saturation and the quarter-wave LUT offset.
package iq_demod_pkg;

  // No overflow: a block of 2^DEC_MAX_LOG2 full-scale products fits.
  function automatic int ACC_W(input int data_w, input int dec_max_log2);
    return 2 * data_w + dec_max_log2;
  endfunction

  // Cosine is the sine table read a quarter turn ahead.
  function automatic int qtr_off(input int lut_aw);
    return 1 << (lut_aw - 2);
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/iq_demod_if.sv
// Sample stream in, I/Q result handshake out.
interface iq_demod_if #(
  parameter int DATA_W = 14,
  parameter int OUT_W  = 14
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] signal;
  logic signed [OUT_W-1:0]  I;
  logic signed [OUT_W-1:0]  Q;
  logic                     out_valid;
  logic                     out_ready;
  logic                     overrun;

  modport master (output in_valid, signal, out_ready, input I, Q, out_valid, overrun);
  modport slave  (input in_valid, signal, out_ready, output I, Q, out_valid, overrun);
endinterface

// File: rtl/iq_sincos_lut.sv
// Dual-port synchronous sine ROM; the second port reads a quarter turn ahead for cosine.
module iq_sincos_lut import iq_demod_pkg::*; #(
  parameter int LUT_AW = 10,
  parameter int DATA_W = 14
) (
  input  logic                     CLK,
  input  logic [LUT_AW-1:0]        addr,
  output logic signed [DATA_W-1:0] sin,
  output logic signed [DATA_W-1:0] cos
);
  localparam int  DEPTH = 1 << LUT_AW;
  localparam real AMP   = real'((1 << (DATA_W - 1)) - 1);

  logic signed [DATA_W-1:0] rom [DEPTH];
  logic [LUT_AW-1:0]        caddr;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam real S = AMP * $sin(6.283185307179586 * k / DEPTH);
    localparam int  V = (S >= 0.0) ? $rtoi(S + 0.5) : -$rtoi(0.5 - S);
    assign rom[k] = DATA_W'(V);
  end

  assign caddr = addr + LUT_AW'(qtr_off(LUT_AW));

  always_ff @(posedge CLK) begin
    sin <= rom[addr];
    cos <= rom[caddr];
  end
endmodule

// File: rtl/iq_demod_core.sv
// IQ lock-in demodulator: NCO, mixers, accumulate-and-dump decimator, result handshake.
// Build option IQ_DEMOD_ROUND_EN: round half-up before the dump shift (default truncates).
module iq_demod_core import iq_demod_pkg::*; #(
  parameter int DATA_W       = 14,
  parameter int PHASE_W      = 32,
  parameter int LUT_AW       = 10,
  parameter int DEC_MAX_LOG2 = 12,
  parameter int OUT_W        = 14
) (
  input  logic                               CLK,
  input  logic                               reset,
  iq_demod_if.slave                          bus,
  input  logic [PHASE_W-1:0]                 phase_inc,
  input  logic [PHASE_W-1:0]                 phase_offset,
  input  logic [$clog2(DEC_MAX_LOG2+1)-1:0]  dec_log2,
  input  logic                               sync
);
  localparam int AW     = ACC_W(DATA_W, DEC_MAX_LOG2);
  localparam int LW     = $clog2(DEC_MAX_LOG2 + 1);
  localparam int STAGES = 2;

  logic [STAGES:0]            vld_pipe;
  logic [PHASE_W-1:0]         phase_acc;
  logic [LUT_AW-1:0]          ph0;
  logic signed [DATA_W-1:0]   sig0, sig1, lut_sin, lut_cos;
  logic signed [2*DATA_W-1:0] prod_i, prod_q;
  logic signed [AW-1:0]       acc_i, acc_q, dmp_i, dmp_q;
  logic [DEC_MAX_LOG2-1:0]    cnt;
  logic [LW-1:0]              blk_l, dmp_l, cur_l, req_l;
  logic                       dmp_vld, last;
  logic signed [63:0]         sh_i, sh_q;

  iq_sincos_lut #(.LUT_AW(LUT_AW), .DATA_W(DATA_W)) u_lut (
    .CLK  (CLK),
    .addr (ph0),
    .sin  (lut_sin),
    .cos  (lut_cos)
  );

  // Stages 0..2: phase/sample capture, LUT read, mix. sync flushes every in-flight flag.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      phase_acc <= '0;
      ph0       <= '0;
      sig0      <= '0;
      sig1      <= '0;
      prod_i    <= '0;
      prod_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
      ph0      <= LUT_AW'((phase_acc + phase_offset) >> (PHASE_W - LUT_AW));
      sig0     <= bus.signal;
      sig1     <= sig0;
      prod_i   <= (2*DATA_W)'(sig1) * (2*DATA_W)'(lut_cos);
      prod_q   <= (2*DATA_W)'(sig1) * (2*DATA_W)'(lut_sin);
      if (sync) begin
        vld_pipe  <= '0;
        phase_acc <= '0;
      end else if (bus.in_valid) begin
        phase_acc <= phase_acc + phase_inc;
      end
    end
  end

  // Block length is taken from dec_log2 only when the first sample of a block lands.
  assign req_l = (dec_log2 > LW'(DEC_MAX_LOG2)) ? LW'(DEC_MAX_LOG2) : dec_log2;
  assign cur_l = (cnt == '0) ? req_l : blk_l;
  assign last  = cnt == DEC_MAX_LOG2'((32'd1 << cur_l) - 32'd1);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      acc_i   <= '0;
      acc_q   <= '0;
      cnt     <= '0;
      blk_l   <= '0;
      dmp_i   <= '0;
      dmp_q   <= '0;
      dmp_l   <= '0;
      dmp_vld <= 1'b0;
    end else begin
      dmp_vld <= 1'b0;
      if (sync) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end else if (vld_pipe[STAGES]) begin
        if (cnt == '0) blk_l <= req_l;
        if (last) begin
          dmp_i   <= acc_i + AW'(prod_i);
          dmp_q   <= acc_q + AW'(prod_q);
          dmp_l   <= cur_l;
          dmp_vld <= 1'b1;
          acc_i   <= '0;
          acc_q   <= '0;
          cnt     <= '0;
        end else begin
          acc_i <= acc_i + AW'(prod_i);
          acc_q <= acc_q + AW'(prod_q);
          cnt   <= cnt + DEC_MAX_LOG2'(1);
        end
      end
    end
  end

  // Normalise by the LUT amplitude and the block length.
  always_comb begin
    sh_i = 64'(dmp_i);
    sh_q = 64'(dmp_q);
`ifdef IQ_DEMOD_ROUND_EN
    sh_i = sh_i + (64'sd1 <<< (DATA_W - 2 + int'(dmp_l)));
    sh_q = sh_q + (64'sd1 <<< (DATA_W - 2 + int'(dmp_l)));
`else
`endif
    sh_i = sh_i >>> (DATA_W - 1 + int'(dmp_l));
    sh_q = sh_q >>> (DATA_W - 1 + int'(dmp_l));
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      bus.I         <= '0;
      bus.Q         <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else if (dmp_vld) begin
      bus.I         <= OUT_W'(sat(sh_i, OUT_W));
      bus.Q         <= OUT_W'(sat(sh_q, OUT_W));
      bus.out_valid <= 1'b1;
      if (bus.out_valid && !bus.out_ready) bus.overrun <= 1'b1;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_iq_demod_core.sv
// Directed bench for iq_demod_core: hand-computed I/Q, latency, handshake, sync and reset.
module tb_iq_demod_core;
  localparam int DATA_W = 14, PHASE_W = 32, LUT_AW = 10, DEC_MAX_LOG2 = 12, OUT_W = 14;
  localparam int LW = $clog2(DEC_MAX_LOG2 + 1);

  logic               CLK = 1'b0;
  logic               reset = 1'b1;
  logic [PHASE_W-1:0] phase_inc, phase_offset;
  logic [LW-1:0]      dec_log2;
  logic               sync;
  int                 total = 0, bad = 0;
  int                 rx_i[$], rx_q[$];

  iq_demod_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus();

  iq_demod_core #(.DATA_W(DATA_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW),
                  .DEC_MAX_LOG2(DEC_MAX_LOG2), .OUT_W(OUT_W)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .bus          (bus),
    .phase_inc    (phase_inc),
    .phase_offset (phase_offset),
    .dec_log2     (dec_log2),
    .sync         (sync)
  );

  always #5 CLK = ~CLK;

  // Record every accepted result.
  always @(negedge CLK) if (bus.out_valid && bus.out_ready) begin
    rx_i.push_back(int'(bus.I));
    rx_q.push_back(int'(bus.Q));
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input int s);
    bus.in_valid = 1'b1;
    bus.signal   = DATA_W'(s);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_sync();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  task automatic clr_rx();
    rx_i.delete();
    rx_q.delete();
  endtask

  function automatic int fs4(input int n);
    case (n % 4)
      0:       return 8191;
      2:       return -8191;
      default: return 0;
    endcase
  endfunction

  task automatic fs4_run(input logic [PHASE_W-1:0] off, input int ei, input int eq, input string tag);
    phase_inc = 32'h4000_0000; phase_offset = off; dec_log2 = LW'(6);
    do_sync();
    clr_rx();
    for (int n = 0; n < 128; n++) send(fs4(n));
    idle(6);
    chk({tag, "_count"}, rx_i.size(), 2);
    for (int r = 0; r < rx_i.size(); r++) begin
      chk({tag, "_I"}, rx_i[r], ei);
      chk({tag, "_Q"}, rx_q[r], eq);
    end
    chk({tag, "_ovr"}, int'(bus.overrun), 0);
  endtask

  initial begin
    int k;
    bus.in_valid = 1'b0; bus.signal = '0; bus.out_ready = 1'b1;
    phase_inc = '0; phase_offset = '0; dec_log2 = '0; sync = 1'b0;
    repeat (3) tick();
    chk("rst_I", int'(bus.I), 0);
    chk("rst_Q", int'(bus.Q), 0);
    chk("rst_vld", int'(bus.out_valid), 0);
    chk("rst_ovr", int'(bus.overrun), 0);
    reset = 1'b0;
    tick();

    // Constant full-scale input at DC, one result per sample.
    send(8191);
    k = 0;
    while (!bus.out_valid && k < 10) begin tick(); k++; end
    chk("latency", k, 4);
    chk("dc_I", int'(bus.I), 8190);
    chk("dc_Q", int'(bus.Q), 0);
    idle(3);

    fs4_run(32'h0000_0000, 4095, 0, "fs4");
    fs4_run(32'h4000_0000, 0, 4095, "rot90");

    // sync at sample 20 of 64, colliding with a sample that must be dropped.
    phase_offset = '0;
    do_sync();
    clr_rx();
    for (int n = 0; n < 20; n++) send(fs4(n));
    bus.in_valid = 1'b1; bus.signal = DATA_W'(8191); sync = 1'b1;
    tick();
    sync = 1'b0; bus.in_valid = 1'b0;
    for (int n = 0; n < 63; n++) send(fs4(n));
    idle(6);
    chk("sync_early", rx_i.size(), 0);
    send(fs4(63));
    idle(6);
    chk("sync_count", rx_i.size(), 1);
    if (rx_i.size() > 0) begin
      chk("sync_I", rx_i[0], 4095);
      chk("sync_Q", rx_q[0], 0);
    end

    // dec_log2 above max clamps to 4096; a mid-block change is ignored.
    phase_inc = '0; dec_log2 = LW'(15);
    do_sync();
    clr_rx();
    for (int n = 0; n < 4095; n++) begin
      if (n == 10) dec_log2 = '0;
      send(-1000);
    end
    idle(6);
    chk("clamp_early", rx_i.size(), 0);
    send(-1000);
    idle(6);
    chk("clamp_count", rx_i.size(), 1);
    if (rx_i.size() > 0) chk("clamp_I", rx_i[0], -1000);

    // Back-to-back dumps while accepting: no overrun.
    dec_log2 = '0;
    do_sync();
    clr_rx();
    send(-1000); send(-2000); send(-3000);
    idle(6);
    chk("b2b_count", rx_i.size(), 3);
    if (rx_i.size() == 3) chk("b2b_I2", rx_i[2], -3000);
    chk("b2b_ovr", int'(bus.overrun), 0);

    // Two dumps with the consumer stalled.
    bus.out_ready = 1'b0;
    send(-1000);
    idle(5);
    chk("ovr1_vld", int'(bus.out_valid), 1);
    chk("ovr1_ovr", int'(bus.overrun), 0);
    chk("ovr1_I", int'(bus.I), -1000);
    send(-2000);
    idle(5);
    chk("ovr2_vld", int'(bus.out_valid), 1);
    chk("ovr2_ovr", int'(bus.overrun), 1);
    chk("ovr2_I", int'(bus.I), -2000);
    chk("ovr2_Q", int'(bus.Q), 0);
    bus.out_ready = 1'b1;
    tick();
    chk("ovr_acc_vld", int'(bus.out_valid), 0);
    chk("ovr_sticky", int'(bus.overrun), 1);

    // Asynchronous reset with a pending result and a partial block.
    bus.out_ready = 1'b0; dec_log2 = LW'(2);
    do_sync();
    repeat (4) send(-1000);
    idle(5);
    chk("pre_rst_vld", int'(bus.out_valid), 1);
    repeat (2) send(-1000);
    #3 reset = 1'b1;
    #1;
    chk("arst_I", int'(bus.I), 0);
    chk("arst_vld", int'(bus.out_valid), 0);
    chk("arst_ovr", int'(bus.overrun), 0);
    #2 reset = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    clr_rx();
    repeat (3) send(-1000);
    idle(6);
    chk("post_rst_early", rx_i.size(), 0);
    send(-1000);
    idle(6);
    chk("post_rst_count", rx_i.size(), 1);
    if (rx_i.size() > 0) chk("post_rst_I", rx_i[0], -1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
